// File: rtl/ram_burst_reader_if.sv
// Bundles the burst command, RAM port-1 and output stream signals of ram_burst_reader.
// The master modport is the reader's view; slave is the view of the surrounding logic.
interface ram_burst_reader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              port_en_1;
  logic [ADDR_W-1:0] addr_in_1;
  logic [DATA_W-1:0] data_out_1;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    input  start, base_addr, length, data_out_1, m_ready,
    output busy, done, port_en_1, addr_in_1, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, length, data_out_1, m_ready,
    input  busy, done, port_en_1, addr_in_1, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read initiator for a RAM port with 1-cycle read latency, delivering a valid/ready stream.
// state | meaning:  IDLE - waiting for start | ISSUE - reads outstanding to issue | DRAIN - all issued, emptying buffer
module ram_burst_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  ram_burst_reader_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_infl_last;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_buf_data [2];
  logic              r_buf_last [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_valid;
  logic              w_pop;
  logic              w_head_last;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_valid      = (r_count != 2'd0);
  assign w_pop        = w_valid & bus.m_ready;
  assign w_head_last  = r_buf_last[r_rd_ptr];
  // Occupancy after this cycle's pop, counting the read whose data arrives now.
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_ISSUE) && (w_occ < 3'd2);
  assign w_issue_last = w_issue && (r_issued == r_len - ONE);
  assign w_next_addr  = r_base + r_issued[ADDR_W-1:0];

  assign bus.port_en_1 = w_issue;
  assign bus.addr_in_1 = w_issue ? w_next_addr : r_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.m_valid   = w_valid;
  assign bus.m_data    = r_buf_data[r_rd_ptr];
  assign bus.m_last    = w_valid & w_head_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_addr        <= '0;
      r_inflight    <= 1'b0;
      r_infl_last   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last[0] <= 1'b0;
      r_buf_last[1] <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      r_done      <= 1'b0;
      r_inflight  <= w_issue;
      r_infl_last <= w_issue_last;
      r_count     <= w_occ[1:0];

      // Read data is tagged with its last flag at issue time and captured here.
      if (r_inflight) begin
        r_buf_data[r_wr_ptr] <= bus.data_out_1;
        r_buf_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_issue) begin
        r_issued <= r_issued + ONE;
        r_addr   <= w_next_addr;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              r_state  <= S_ISSUE;
              r_base   <= bus.base_addr;
              r_len    <= bus.length;
              r_issued <= '0;
              r_busy   <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: RAM model preloaded with mem[a] = a+1,
// burst table plus random bursts checked against an address/data arithmetic model.
module tb_ram_burst_reader;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  initial for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(a + 1);

  always @(posedge clk) begin
    if (rst) bus.data_out_1 <= '0;
    else if (bus.port_en_1) bus.data_out_1 <= mem[bus.addr_in_1];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_port_en"}, bus.port_en_1, 0);
    chk({tag, "_addr"},    bus.addr_in_1, 0);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_done"},    bus.done, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"},  bus.m_data, 0);
    chk({tag, "_m_last"},  bus.m_last, 0);
  endtask

  task automatic run_burst(input int base, input int len, input bit rnd, input int exp_cnt,
                           input int exp_first, input int exp_lastd, input bit poke);
    int got[$];
    int issued = 0, accepted = 0, done_seen = 0;
    int last_hs = -100, first_hs = -1, first_en = -1, first_val = -1;
    int occ;
    int budget = len * 12 + 40;
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = ADDR_W'(base);
    bus.length    = (ADDR_W+1)'(len);
    bus.m_ready   = 1'b1;
    #1;
    chk("idle_busy", bus.busy, 0);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 3) begin
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(40);
        bus.length    = (ADDR_W+1)'(20);
      end else begin
        bus.start     = 1'b0;
        bus.base_addr = ADDR_W'($urandom);
        bus.length    = (ADDR_W+1)'($urandom);
      end
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.port_en_1) begin
        if (first_en < 0) first_en = cyc;
        occ = issued - accepted - ((bus.m_valid && bus.m_ready) ? 1 : 0);
        chk("addr", bus.addr_in_1, (base + issued) % DEPTH);
        chk("no_overflow", (occ < 2) ? 1 : 0, 1);
        issued++;
      end
      if (prev_stall) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, prev_data);
        chk("hold_last", bus.m_last, prev_last);
      end
      if (bus.m_valid && first_val < 0) first_val = cyc;
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(int'(bus.m_data));
        chk("last_flag", bus.m_last, (accepted == len - 1) ? 1 : 0);
        if (first_hs < 0) first_hs = cyc;
        accepted++;
        last_hs = cyc;
      end
      if (bus.done) begin
        done_seen++;
        chk("done_timing", cyc, last_hs + 1);
        chk("busy_at_done", bus.busy, 0);
      end else begin
        chk("busy", bus.busy, (done_seen == 0) ? 1 : 0);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (done_seen > 0 && cyc >= last_hs + 3) break;
    end
    bus.m_ready = 1'b1;

    chk("word_count", got.size(), exp_cnt);
    for (int i = 0; i < got.size(); i++)
      chk("data", got[i], ((base + i) % DEPTH) + 1);
    if (got.size() > 0) begin
      chk("first_word", got[0], exp_first);
      chk("final_word", got[got.size()-1], exp_lastd);
    end
    chk("issued", issued, len);
    chk("done_count", done_seen, 1);
    chk("first_en_lat", first_en, 1);
    chk("first_valid_lat", first_val, 3);
    if (!rnd) chk("throughput", last_hs - first_hs, len - 1);
  endtask

  typedef struct {
    int base;
    int len;
    bit rnd;
    int exp_cnt;
    int exp_first;
    int exp_lastd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int en, val, dn, acc;
    vecs[0] = '{base: 0,  len: 16, rnd: 1'b0, exp_cnt: 16, exp_first: 1,  exp_lastd: 16};
    vecs[1] = '{base: 60, len: 8,  rnd: 1'b0, exp_cnt: 8,  exp_first: 61, exp_lastd: 4};
    vecs[2] = '{base: 5,  len: 10, rnd: 1'b1, exp_cnt: 10, exp_first: 6,  exp_lastd: 15};
    vecs[3] = '{base: 32, len: 64, rnd: 1'b0, exp_cnt: 64, exp_first: 33, exp_lastd: 32};
    vecs[4] = '{base: 0,  len: 1,  rnd: 1'b0, exp_cnt: 1,  exp_first: 1,  exp_lastd: 1};
    vecs[5] = '{base: 63, len: 3,  rnd: 1'b1, exp_cnt: 3,  exp_first: 64, exp_lastd: 2};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    bus.m_ready = 1'b1;

    foreach (vecs[i])
      run_burst(vecs[i].base, vecs[i].len, vecs[i].rnd, vecs[i].exp_cnt,
                vecs[i].exp_first, vecs[i].exp_lastd, 1'b0);

    // A second start (base=40) during a busy burst must be ignored.
    run_burst(10, 20, 1'b0, 20, 11, 30, 1'b1);

    // Zero-length command: done pulse only.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = ADDR_W'(7); bus.length = '0;
    #1;
    en = bus.port_en_1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("zero_done", bus.done, 1);
    chk("zero_busy", bus.busy, 0);
    en += bus.port_en_1; val = bus.m_valid; dn = 0;
    repeat (6) begin
      @(negedge clk); #1;
      en += bus.port_en_1; val += bus.m_valid; dn += bus.done;
    end
    chk("zero_port_en", en, 0);
    chk("zero_m_valid", val, 0);
    chk("zero_extra_done", dn, 0);

    // Reset mid-burst after three accepted words.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = '0; bus.length = (ADDR_W+1)'(8); bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    acc = 0;
    for (int c = 0; c < 40 && acc < 3; c++) begin
      #1;
      if (bus.m_valid && bus.m_ready) acc++;
      if (acc < 3) @(negedge clk);
    end
    chk("pre_reset_words", acc, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("midreset");
    rst = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clk); #1;
      dn += bus.done;
    end
    chk("midreset_no_done", dn, 0);
    run_burst(0, 2, 1'b0, 2, 1, 2, 1'b0);

    for (int k = 0; k < 4; k++) begin
      int b, l;
      bit r;
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, DEPTH);
      r = 1'($urandom_range(0, 1));
      run_burst(b, l, r, l, (b % DEPTH) + 1, ((b + l - 1) % DEPTH) + 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
